// File: rtl/sample_packetizer.sv
// Frames 32-bit samples from a FIFO into SYNC/SEQ/DATA/CSUM byte packets on a
// valid/ready byte stream, with a per-packet wrapping sequence number.
module sample_packetizer #(
  parameter int unsigned SAMPLES_PER_PACKET = 4,
  parameter logic [7:0]  SYNC_BYTE          = 8'hA5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_q,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        packet_done,
  output logic [7:0]  seq_num
);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StSeq,
    StFetch,
    StLoad,
    StData,
    StCsum
  } state_e;

  localparam logic [7:0] LastWord = 8'(SAMPLES_PER_PACKET - 1);

  state_e      state;
  logic [7:0]  csum;
  logic [7:0]  word_cnt;
  logic [1:0]  byte_idx;
  // Holds only the bytes not yet presented; the MSB goes straight to byte_data.
  logic [23:0] shift;
  logic        xfer;

  assign xfer = byte_valid && byte_ready;

  // Decoded from the state register so the FIFO sees RdEn on the edge that
  // leaves FETCH and Q is ready to capture on the following LOAD edge.
  assign fifo_rd_en = (state == StFetch) && !fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      csum        <= 8'h00;
      word_cnt    <= 8'h00;
      byte_idx    <= 2'd0;
      shift       <= 24'h000000;
      byte_data   <= 8'h00;
      byte_valid  <= 1'b0;
      busy        <= 1'b0;
      packet_done <= 1'b0;
      seq_num     <= 8'h00;
    end else begin
      packet_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (enable && !fifo_empty) begin
            state      <= StSync;
            busy       <= 1'b1;
            byte_valid <= 1'b1;
            byte_data  <= SYNC_BYTE;
            csum       <= 8'h00;
            word_cnt   <= 8'h00;
          end
        end
        StSync: begin
          if (xfer) begin
            state     <= StSeq;
            byte_data <= seq_num;
          end
        end
        StSeq: begin
          if (xfer) begin
            csum       <= csum + seq_num;
            byte_valid <= 1'b0;
            state      <= StFetch;
          end
        end
        StFetch: begin
          if (!fifo_empty) begin
            state <= StLoad;
          end
        end
        StLoad: begin
          shift      <= fifo_q[23:0];
          byte_data  <= fifo_q[31:24];
          byte_valid <= 1'b1;
          byte_idx   <= 2'd0;
          state      <= StData;
        end
        StData: begin
          if (xfer) begin
            csum     <= csum + byte_data;
            shift    <= {shift[15:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (word_cnt == LastWord) begin
                // Present the final sum directly, including this last data byte.
                byte_data <= csum + byte_data;
                state     <= StCsum;
              end else begin
                word_cnt   <= word_cnt + 8'd1;
                byte_valid <= 1'b0;
                state      <= StFetch;
              end
            end else begin
              byte_data <= shift[23:16];
            end
          end
        end
        StCsum: begin
          if (xfer) begin
            seq_num     <= seq_num + 8'd1;
            packet_done <= 1'b1;
            busy        <= 1'b0;
            byte_valid  <= 1'b0;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_packetizer.sv
// Directed bench for sample_packetizer: FIFO model, byte logger and stall
// monitor, with hand-computed packet contents checked by immediate assertions.
module tb_sample_packetizer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_q = 32'h0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        packet_done;
  logic [7:0]  seq_num;

  logic        ready_fix;
  logic        rand_mode;
  logic        rand_ready = 1'b0;

  logic [31:0] mem [2048];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic [7:0]  byte_log [8192];
  int          nlog = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;
  int          stall_errs = 0;
  int          rd_errs = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  held = 8'h00;

  int          n_tests = 0;
  int          n_fail = 0;

  sample_packetizer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_q     (fifo_q),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .packet_done(packet_done),
    .seq_num    (seq_num)
  );

  always #5 clock = ~clock;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign byte_ready = rand_mode ? rand_ready : ready_fix;

  always @(negedge clock) rand_ready <= ($urandom_range(0, 99) < 30);

  // One-cycle-latency FIFO read port.
  always @(posedge clock) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(posedge clock) begin
    if (byte_valid && byte_ready) begin
      byte_log[nlog] <= byte_data;
      nlog <= nlog + 1;
    end
    if (packet_done) done_cnt <= done_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (fifo_rd_en && fifo_empty) rd_errs <= rd_errs + 1;
    if (reset_n && stall_prev && (!byte_valid || byte_data !== held))
      stall_errs <= stall_errs + 1;
    stall_prev <= reset_n && byte_valid && !byte_ready;
    held <= byte_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_bytes(input int target, input int limit);
    int n = 0;
    while (nlog < target && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk("wait_bytes", 32'(nlog >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk("wait_done", 32'(done_cnt >= target), 32'd1);
  endtask

  function automatic logic [7:0] sum_words(input logic [7:0] seq, input logic [31:0] w0,
                                           input logic [31:0] w1, input logic [31:0] w2,
                                           input logic [31:0] w3);
    logic [31:0] w [4];
    logic [7:0]  s;
    w = '{w0, w1, w2, w3};
    s = seq;
    for (int i = 0; i < 4; i++)
      s = s + w[i][31:24] + w[i][23:16] + w[i][15:8] + w[i][7:0];
    return s;
  endfunction

  task automatic check_packet(input string tag, input int base, input logic [7:0] seq,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    logic [7:0]  exp [19];
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    exp[0] = 8'hA5;
    exp[1] = seq;
    for (int i = 0; i < 4; i++) begin
      exp[2 + 4*i]     = w[i][31:24];
      exp[2 + 4*i + 1] = w[i][23:16];
      exp[2 + 4*i + 2] = w[i][15:8];
      exp[2 + 4*i + 3] = w[i][7:0];
    end
    exp[18] = sum_words(seq, w0, w1, w2, w3);
    for (int i = 0; i < 19; i++)
      chk($sformatf("%s byte %0d", tag, i), 32'(byte_log[base + i]), 32'(exp[i]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, " valid"}, 32'(byte_valid), 32'd0);
    chk({tag, " data"}, 32'(byte_data), 32'h00);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(packet_done), 32'd0);
    chk({tag, " seq"}, 32'(seq_num), 32'h00);
  endtask

  initial begin
    int base;
    int b0;
    int d0;
    int uf_bad;
    logic [7:0] exp_csum;

    reset_n   = 1'b0;
    enable    = 1'b0;
    ready_fix = 1'b1;
    rand_mode = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Single packet, ready held high.
    base = nlog;
    b0 = busy_cyc;
    push(32'h01020304); push(32'h05060708); push(32'h090A0B0C); push(32'h0D0E0F10);
    enable = 1'b1;
    wait_done(1, 200);
    repeat (3) @(negedge clock);
    check_packet("single", base, 8'h00, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    chk("single csum", 32'(byte_log[base + 18]), 32'h88);
    chk("single seq_num", 32'(seq_num), 32'h01);
    chk("single done count", 32'(done_cnt), 32'd1);
    chk("single busy cycles", 32'(busy_cyc - b0), 32'd27);

    // Back-pressure at ~30% ready.
    base = nlog;
    push(32'h01020304); push(32'h05060708); push(32'h090A0B0C); push(32'h0D0E0F10);
    rand_mode = 1'b1;
    wait_done(2, 3000);
    rand_mode = 1'b0;
    check_packet("bp", base, 8'h01, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    chk("bp stall stable", 32'(stall_errs), 32'd0);

    // FIFO runs dry after the second word.
    base = nlog;
    push(32'h01020304); push(32'h05060708);
    wait_bytes(base + 10, 200);
    uf_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (fifo_rd_en !== 1'b0 || byte_valid !== 1'b0 || busy !== 1'b1) uf_bad++;
    end
    chk("underflow idle outputs", 32'(uf_bad), 32'd0);
    push(32'h090A0B0C); push(32'h0D0E0F10);
    wait_done(3, 200);
    check_packet("uf", base, 8'h02, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    chk("rd_en never while empty", 32'(rd_errs), 32'd0);

    // Enable dropped during the first data word.
    base = nlog;
    push(32'hDEADBEEF); push(32'h12345678); push(32'hCAFEF00D); push(32'h0BADC0DE);
    wait_bytes(base + 3, 200);
    enable = 1'b0;
    push(32'h00000000);
    wait_done(4, 200);
    repeat (10) @(negedge clock);
    check_packet("en_drop", base, 8'h03, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE);
    chk("en_drop busy", 32'(busy), 32'd0);
    chk("en_drop fifo kept", 32'(fifo_empty), 32'd0);
    chk("en_drop done count", 32'(done_cnt), 32'd4);

    // Reset while the checksum byte is stalled.
    push(32'h11223344); push(32'h55667788); push(32'h99AABBCC);
    base = nlog;
    enable = 1'b1;
    wait_bytes(base + 18, 200);
    ready_fix = 1'b0;
    repeat (2) @(negedge clock);
    exp_csum = sum_words(8'h04, 32'h00000000, 32'h11223344, 32'h55667788, 32'h99AABBCC);
    chk("csum stall valid", 32'(byte_valid), 32'd1);
    chk("csum stall data", 32'(byte_data), 32'(exp_csum));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("async reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    ready_fix = 1'b1;
    base = nlog;
    d0 = done_cnt;
    push(32'h01020304); push(32'h05060708); push(32'h090A0B0C); push(32'h0D0E0F10);
    wait_done(d0 + 1, 200);
    check_packet("post_reset", base, 8'h00, 32'h01020304, 32'h05060708, 32'h090A0B0C,
                 32'h0D0E0F10);

    // Sequence wrap over 257 zero packets starting from seq 0.
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    base = nlog;
    d0 = done_cnt;
    for (int i = 0; i < 257 * 4; i++) push(32'h00000000);
    wait_done(d0 + 257, 257 * 40);
    chk("wrap pkt1 seq", 32'(byte_log[base + 1]), 32'h00);
    chk("wrap pkt256 seq", 32'(byte_log[base + 255*19 + 1]), 32'hFF);
    chk("wrap pkt256 csum", 32'(byte_log[base + 255*19 + 18]), 32'hFF);
    chk("wrap pkt257 seq", 32'(byte_log[base + 256*19 + 1]), 32'h00);
    chk("wrap pkt257 csum", 32'(byte_log[base + 256*19 + 18]), 32'h00);
    chk("wrap seq_num", 32'(seq_num), 32'h01);
    chk("final stall stable", 32'(stall_errs), 32'd0);
    chk("final rd_en never while empty", 32'(rd_errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_packetizer.md
# sample_packetizer

Frames 32-bit ADC samples drained from the sample FIFO into a checksummed byte-stream packet for the serial/storage transmit path. It sits directly downstream of `fifo_buffer`, which `adc_serial_interface` fills, and upstream of a byte-oriented sink such as the RS-232 encoder or the storage interface. It owns the FIFO read port: read enable in, data and empty flag back. The result is a back-pressured byte stream with a per-packet sequence number.

## Interface
- `SAMPLES_PER_PACKET`, default 4: 32-bit words per packet. Legal range is 1..255.
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.
- `clock` in 1: single clock domain, the 84 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: packetizing permitted. Sampled only in IDLE.
- `fifo_empty` in 1: FIFO Empty flag.
- `fifo_rd_en` out 1: FIFO RdEn. Single-cycle pulses only.
- `fifo_q` in 32: FIFO Q. Valid on the cycle after `fifo_rd_en` is high.
- `byte_data` out 8: outgoing byte.
- `byte_valid` out 1: `byte_data` is valid.
- `byte_ready` in 1: sink accepts the byte. A transfer occurs on a rising edge with `byte_valid && byte_ready`.
- `busy` out 1: high in every state except IDLE.
- `packet_done` out 1: one-cycle pulse on the cycle after the checksum byte transfers.
- `seq_num` out 8: sequence number of the next packet to be sent.

## Operation
- Packet format, in order:
  - `SYNC_BYTE`
  - `seq_num`
  - `SAMPLES_PER_PACKET` words, 4 bytes each, MSB first
  - checksum
- Checksum is the 8-bit sum, mod 256, of the seq byte and all data bytes. `SYNC_BYTE` is excluded.
- States: IDLE, SYNC, SEQ, FETCH, LOAD, DATA, CSUM.
- IDLE:
  - If `enable && !fifo_empty`, go to SYNC.
  - Otherwise stay in IDLE.
  - On entry to SYNC, the checksum accumulator and the word counter clear.
- SYNC: present `SYNC_BYTE`. On transfer go to SEQ.
- SEQ: present `seq_num`, and add it to the checksum on transfer. Go to FETCH.
- FETCH:
  - If `!fifo_empty`, pulse `fifo_rd_en` and go to LOAD.
  - Otherwise stall in FETCH with `byte_valid`=0. There is no timeout.
- LOAD: capture `fifo_q` into the shift register, clear the byte index, and go to DATA.
- DATA:
  - Present shift[31:24]. On transfer, add it to the checksum, shift left 8, and increment the byte index.
  - After the 4th byte: if word count is `SAMPLES_PER_PACKET`-1, go to CSUM. Otherwise increment word count and go to FETCH.
- CSUM:
  - Present the checksum. On transfer, increment `seq_num` (wraps 8'hFF to 8'h00), pulse `packet_done`, and go to IDLE.
- `enable` deasserted mid-packet has no effect. The current packet always completes, and the next IDLE does not restart it.
- `byte_data` must hold stable while `byte_valid && !byte_ready`. `byte_valid` never drops without a transfer, except on reset.
- `fifo_rd_en` is never asserted when `fifo_empty`=1. It is never asserted outside FETCH.
- Widths:
  - Checksum is an 8-bit register that wraps.
  - Word counter is 8 bits.
  - Byte index is 2 bits.

## Timing
- Reset values while `reset_n`=0:
  - state IDLE
  - `fifo_rd_en`=0, `byte_valid`=0, `byte_data`=8'h00
  - `busy`=0, `packet_done`=0, `seq_num`=8'h00
  - checksum 0, counters 0
- Reset mid-packet aborts immediately. No checksum byte is sent, and `seq_num` returns to 0.
- Outputs are registered. `byte_valid` rises on the first edge after the state is entered.
- A zero-stall packet takes 1 (IDLE→SYNC) + 2 + `SAMPLES_PER_PACKET`×(2 + 4) + 1 cycles from the IDLE decision to the checksum transfer, with `byte_ready` held high. The 2 in each word is FETCH plus LOAD.
- FIFO read latency is 1 cycle: RdEn at edge N, Q sampled at edge N+1 in LOAD.
- `packet_done` is high for exactly one cycle, coincident with the return to IDLE.
- Back-to-back packets: at least one IDLE cycle between packets.

## Test plan
- Single packet, default parameters, FIFO preloaded with 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, `byte_ready`=1:
  - Bytes are A5, 00, 01..10, checksum 8'h88.
  - `seq_num` becomes 1.
  - `packet_done` pulses once.
- Back-pressure: `byte_ready` random at 30% duty. The byte sequence is identical to the single-packet case, and `byte_data` is stable during every stall.
- FIFO underflow: FIFO empty after word 2 for 50 cycles. `fifo_rd_en` stays 0 and `byte_valid`=0 in FETCH. The packet resumes correctly when a word arrives.
- Sequence wrap: 257 packets of 32'h00000000.
  - The seq byte of packet 256 is 8'hFF, with checksum 8'hFF.
  - The seq byte of packet 257 is 8'h00.
- `enable` dropped during DATA of word 1: the packet completes, then `busy`=0 with the FIFO still non-empty.
- `reset_n` pulsed during CSUM: all outputs reach their reset values asynchronously. The next packet starts with seq 8'h00 and a fresh checksum.
